// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: PC register, in-order imem requests, DEPTH-entry prefetch queue, redirect flush/squash.
// Latency: a response word is visible on inst_* the cycle after it arrives; a request is raised combinationally from state.
// Backpressure: requests stop while queued + outstanding fetches reach DEPTH; inst_ready low simply holds the queue head.
module fetch_unit #(
   parameter int                ADDR_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h00400000)
) (
   input  logic                         clock,
   input  logic                         reset,
   output logic                         imem_req_valid,
   input  logic                         imem_req_ready,
   output logic [ADDR_W-1:0]            imem_req_addr,
   input  logic                         imem_rsp_valid,
   input  logic [31:0]                  imem_rsp_data,
   input  logic                         redirect_valid,
   input  logic [ADDR_W-1:0]            redirect_pc,
   output logic                         inst_valid,
   input  logic                         inst_ready,
   output logic [31:0]                  inst_data,
   output logic [ADDR_W-1:0]            inst_pc,
   output logic [ADDR_W-1:0]            inst_pc_4,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   logic              run_q;
   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] rsp_pc;
   logic [CW-1:0]     count;
   logic [CW-1:0]     outstanding;
   logic [CW-1:0]     drop_cnt;
   logic [CW-1:0]     out_nxt;
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [31:0]       data_q [DEPTH];
   logic [ADDR_W-1:0] pc_q   [DEPTH];

   logic              credit_ok;
   logic              req_fire;
   logic              push;
   logic              pop;
   logic [ADDR_W-1:0] target_pc;

   // Credits cover both queued words and fetches still in flight, so a push can never find the queue full.
   assign credit_ok      = ({1'b0, count} + {1'b0, outstanding}) < (CW+1)'(DEPTH);
   assign imem_req_valid = run_q && !redirect_valid && credit_ok;
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // A response is squashed if it belongs to a pre-redirect fetch or arrives in the redirect cycle itself.
   assign push      = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
   assign pop       = inst_valid && inst_ready;
   assign target_pc = redirect_pc & ~ADDR_W'(3);

   // Head of queue; zeroed when empty so the idle outputs match the reset values.
   assign inst_valid = (count != '0);
   assign inst_data  = inst_valid ? data_q[rd_ptr] : 32'h0;
   assign inst_pc    = inst_valid ? pc_q[rd_ptr] : '0;
   assign inst_pc_4  = inst_pc + ADDR_W'(4);
   assign occupancy  = count;

   // Live outstanding count after this cycle's accept and response; also the drop count on a redirect.
   always_comb begin
      out_nxt = outstanding;
      if (req_fire)       out_nxt = out_nxt + CW'(1);
      if (imem_rsp_valid) out_nxt = out_nxt - CW'(1);
   end

   // Fetch/response PCs, credit counters and queue pointers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         run_q       <= 1'b0;
         fetch_pc    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         count       <= '0;
         outstanding <= '0;
         drop_cnt    <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
      end else begin
         run_q       <= 1'b1;
         outstanding <= out_nxt;
         if (redirect_valid) begin
            fetch_pc <= target_pc;
            rsp_pc   <= target_pc;
            count    <= '0;
            drop_cnt <= out_nxt;
            rd_ptr   <= wr_ptr;
         end else begin
            if (req_fire) fetch_pc <= fetch_pc + ADDR_W'(4);
            if (push) begin
               rsp_pc <= rsp_pc + ADDR_W'(4);
               wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
            if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
         end
      end
   end

   // Queue storage; contents are only observed through count, so no reset is needed.
   always_ff @(posedge clock) begin
      if (push) begin
         data_q[wr_ptr] <= imem_rsp_data;
         pc_q[wr_ptr]   <= rsp_pc;
      end
   end

endmodule
